// File: rtl/mix_weight_update_pkg.sv
// Shared constants for the mix-layer train path: dimension defaults, region sizes,
// optimizer FSM encoding and the per-layer region base lookup.
package mix_weight_update_pkg;

  localparam int MWU_ADDR_WIDTH = 9;
  localparam int MWU_HID_DIM    = 24;
  localparam int MWU_DATA_N     = 8;
  localparam int MWU_W_LEN      = 24;
  localparam int MWU_LR_SHIFT   = 6;

  localparam int MWU_N_W = MWU_HID_DIM * MWU_HID_DIM / MWU_DATA_N;
  localparam int MWU_N_B = MWU_HID_DIM;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_W,
    ST_RD_B,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Layer regions are packed back to back; the illegal select 3 aliases layer 0.
  function automatic int layer_base(input logic [1:0] lsel, input int region_len);
    case (lsel)
      2'd1:    return region_len;
      2'd2:    return 2 * region_len;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/mix_weight_update_sgd_word.sv
// One-word SGD step: w - (grad >>> LR_SHIFT), purely combinational.
// MIX_WEIGHT_UPDATE_SAT_EN clamps the result to the signed W_LEN range instead of wrapping.
module mix_weight_update_sgd_word #(
  parameter int W_LEN    = 24,
  parameter int LR_SHIFT = 6
) (
  input  logic [W_LEN-1:0] i_w,
  input  logic [W_LEN-1:0] i_grad,
  output logic [W_LEN-1:0] o_w
);

  logic signed [W_LEN-1:0] w_step;

  assign w_step = $signed(i_grad) >>> LR_SHIFT;

`ifdef MIX_WEIGHT_UPDATE_SAT_EN
  logic signed [W_LEN:0] w_diff;

  assign w_diff = $signed({i_w[W_LEN-1], i_w}) - $signed({w_step[W_LEN-1], w_step});

  // The two top bits disagree exactly when the difference left the W_LEN range.
  always_comb begin
    o_w = w_diff[W_LEN-1:0];
    if (w_diff[W_LEN] != w_diff[W_LEN-1]) begin
      o_w = w_diff[W_LEN] ? {1'b1, {(W_LEN-1){1'b0}}} : {1'b0, {(W_LEN-1){1'b1}}};
    end
  end
`else
  assign o_w = i_w - w_step;
`endif

endmodule

// File: rtl/mix_weight_update.sv
// SGD optimizer for one mix layer: walks weight rows then bias words, writes w - grad>>>LR_SHIFT
// two cycles after each read and clears the gradient in the same write. MIX_WEIGHT_UPDATE_SAT_EN selects saturation.
module mix_weight_update
  import mix_weight_update_pkg::*;
#(
  parameter int ADDR_WIDTH = MWU_ADDR_WIDTH,
  parameter int HID_DIM    = MWU_HID_DIM,
  parameter int DATA_N     = MWU_DATA_N,
  parameter int W_LEN      = MWU_W_LEN,
  parameter int LR_SHIFT   = MWU_LR_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [1:0]               sel,
  output logic                     valid,
  output logic [ADDR_WIDTH-1:0]    raddr_w,
  input  logic [DATA_N*W_LEN-1:0]  rdata_w,
  input  logic [DATA_N*W_LEN-1:0]  rdata_grad_w,
  output logic [ADDR_WIDTH-1:0]    waddr_w,
  output logic [DATA_N*W_LEN-1:0]  wdata_w,
  output logic                     we_w,
  output logic [ADDR_WIDTH-1:0]    raddr_b,
  input  logic [W_LEN-1:0]         rdata_b,
  input  logic [W_LEN-1:0]         rdata_grad_b,
  output logic [ADDR_WIDTH-1:0]    waddr_b,
  output logic [W_LEN-1:0]         wdata_b,
  output logic                     we_b
);

  localparam int N_W = HID_DIM * HID_DIM / DATA_N;
  localparam int N_B = HID_DIM;
  localparam int CW  = $clog2(N_W + 1);

  state_t                    r_state;
  logic [1:0]                r_sel;
  logic [CW-1:0]             r_cnt;
  logic                      r_pv_w;
  logic                      r_pv_b;
  logic                      r_d1_vld_w;
  logic                      r_d1_vld_b;
  logic [ADDR_WIDTH-1:0]     r_d1_addr_w;
  logic [ADDR_WIDTH-1:0]     r_d1_addr_b;
  logic [DATA_N*W_LEN-1:0]   w_new_row;
  logic [W_LEN-1:0]          w_new_b;

  for (genvar gi = 0; gi < DATA_N; gi++) begin : g_word
    mix_weight_update_sgd_word #(
      .W_LEN    (W_LEN),
      .LR_SHIFT (LR_SHIFT)
    ) u_word (
      .i_w    (rdata_w[gi*W_LEN +: W_LEN]),
      .i_grad (rdata_grad_w[gi*W_LEN +: W_LEN]),
      .o_w    (w_new_row[gi*W_LEN +: W_LEN])
    );
  end

  mix_weight_update_sgd_word #(
    .W_LEN    (W_LEN),
    .LR_SHIFT (LR_SHIFT)
  ) u_bias (
    .i_w    (rdata_b),
    .i_grad (rdata_grad_b),
    .o_w    (w_new_b)
  );

  // r_pv_* marks that the address currently on raddr_* is a real read; it rides
  // the pipeline through r_d1_vld_* (data cycle) into we_* (write cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_pv_w      <= 1'b0;
      r_pv_b      <= 1'b0;
      r_d1_vld_w  <= 1'b0;
      r_d1_vld_b  <= 1'b0;
      r_d1_addr_w <= '0;
      r_d1_addr_b <= '0;
      valid       <= 1'b0;
      raddr_w     <= '0;
      waddr_w     <= '0;
      wdata_w     <= '0;
      we_w        <= 1'b0;
      raddr_b     <= '0;
      waddr_b     <= '0;
      wdata_b     <= '0;
      we_b        <= 1'b0;
    end else if (r_state != ST_IDLE && !run) begin
      r_state    <= ST_IDLE;
      valid      <= 1'b0;
      r_pv_w     <= 1'b0;
      r_pv_b     <= 1'b0;
      r_d1_vld_w <= 1'b0;
      r_d1_vld_b <= 1'b0;
      we_w       <= 1'b0;
      we_b       <= 1'b0;
    end else begin
      r_d1_vld_w  <= r_pv_w;
      r_d1_addr_w <= raddr_w;
      r_d1_vld_b  <= r_pv_b;
      r_d1_addr_b <= raddr_b;
      we_w        <= r_d1_vld_w;
      we_b        <= r_d1_vld_b;
      if (r_d1_vld_w) begin
        waddr_w <= r_d1_addr_w;
        wdata_w <= w_new_row;
      end
      if (r_d1_vld_b) begin
        waddr_b <= r_d1_addr_b;
        wdata_b <= w_new_b;
      end

      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_sel   <= (sel == 2'd3) ? 2'd0 : sel;
            raddr_w <= ADDR_WIDTH'(layer_base(sel, N_W));
            r_pv_w  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_RD_W;
          end
        end
        ST_RD_W: begin
          // One turnaround cycle after the last row before bias reads begin.
          if (r_cnt == CW'(N_W)) begin
            raddr_b <= ADDR_WIDTH'(layer_base(r_sel, N_B));
            r_pv_b  <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_RD_B;
          end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_pv_w <= (r_cnt < CW'(N_W - 1));
            if (r_cnt < CW'(N_W - 1)) begin
              raddr_w <= raddr_w + ADDR_WIDTH'(1);
            end
          end
        end
        ST_RD_B: begin
          if (r_cnt == CW'(N_B - 1)) begin
            r_pv_b  <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
            raddr_b <= raddr_b + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          if (r_cnt == CW'(1)) begin
            valid   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          valid <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_weight_update.sv
// Directed bench for mix_weight_update with synchronous weight/grad memory models.
module tb_mix_weight_update;

  localparam int AW = 9;
  localparam int DN = 8;
  localparam int WL = 24;
  localparam int RW = DN * WL;

`ifdef MIX_WEIGHT_UPDATE_SAT_EN
  localparam logic [WL-1:0] EXP_OVF = 24'h7FFFFF;
`else
  localparam logic [WL-1:0] EXP_OVF = 24'h800030;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [1:0]    sel;
  logic          valid;
  logic [AW-1:0] raddr_w;
  logic [RW-1:0] rdata_w;
  logic [RW-1:0] rdata_grad_w;
  logic [AW-1:0] waddr_w;
  logic [RW-1:0] wdata_w;
  logic          we_w;
  logic [AW-1:0] raddr_b;
  logic [WL-1:0] rdata_b;
  logic [WL-1:0] rdata_grad_b;
  logic [AW-1:0] waddr_b;
  logic [WL-1:0] wdata_b;
  logic          we_b;

  logic [RW-1:0] wmem  [0:511];
  logic [RW-1:0] gwmem [0:511];
  logic [WL-1:0] bmem  [0:511];
  logic [WL-1:0] gbmem [0:511];
  logic          init_req;
  logic [WL-1:0] init_w;
  logic [WL-1:0] init_g;

  int errs   = 0;
  int checks = 0;
  int last_nw;
  int last_nb;
  int last_vcyc;

  mix_weight_update dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .sel          (sel),
    .valid        (valid),
    .raddr_w      (raddr_w),
    .rdata_w      (rdata_w),
    .rdata_grad_w (rdata_grad_w),
    .waddr_w      (waddr_w),
    .wdata_w      (wdata_w),
    .we_w         (we_w),
    .raddr_b      (raddr_b),
    .rdata_b      (rdata_b),
    .rdata_grad_b (rdata_grad_b),
    .waddr_b      (waddr_b),
    .wdata_b      (wdata_b),
    .we_b         (we_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rdata_w      <= wmem[raddr_w];
    rdata_grad_w <= gwmem[raddr_w];
    rdata_b      <= bmem[raddr_b];
    rdata_grad_b <= gbmem[raddr_b];
    if (init_req) begin
      for (int i = 0; i < 512; i++) begin
        wmem[i]  <= {DN{init_w}};
        gwmem[i] <= {DN{init_g}};
        bmem[i]  <= init_w;
        gbmem[i] <= init_g;
      end
    end else begin
      if (we_w) begin
        wmem[waddr_w]  <= wdata_w;
        gwmem[waddr_w] <= '0;
      end
      if (we_b) begin
        bmem[waddr_b]  <= wdata_b;
        gbmem[waddr_b] <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [WL-1:0] w, input logic [WL-1:0] g);
    init_w   = w;
    init_g   = g;
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  // Starts a run at the current negedge (cycle 0) and checks every write as it appears.
  task automatic do_run(input logic [1:0] s, input int stop_cyc, input bit use_rst,
                        input logic [WL-1:0] ew, input logic [WL-1:0] eb);
    int nw;
    int nb;
    int cyc;
    int bw;
    int bb;
    bit done;
    bw = (s == 2'd3) ? 0 : int'(s) * 72;
    bb = (s == 2'd3) ? 0 : int'(s) * 24;
    sel = s;
    run = 1'b1;
    nw = 0;
    nb = 0;
    cyc = 0;
    done = 1'b0;
    last_vcyc = -1;
    while (!done && cyc < 150) begin
      @(negedge clk);
      cyc++;
      if (we_w) begin
        chk("w_cycle", cyc, nw + 3);
        chk("w_addr", waddr_w, bw + nw);
        chk("w_data", wdata_w, {DN{ew}});
        nw++;
      end
      if (we_b) begin
        chk("b_cycle", cyc, 72 + nb + 4);
        chk("b_addr", waddr_b, bb + nb);
        chk("b_data", wdata_b, eb);
        nb++;
      end
      if (valid) begin
        last_vcyc = cyc;
        done = 1'b1;
      end
      if (cyc == stop_cyc) begin
        if (use_rst) begin
          rst = 1'b1;
          #1;
          chk("rst_wdata", wdata_w, '0);
          chk("rst_ctl", {valid, raddr_w, waddr_w, we_w, raddr_b, waddr_b, wdata_b, we_b}, '0);
        end else begin
          run = 1'b0;
          for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_quiet", {we_w, we_b, valid}, '0);
          end
        end
        done = 1'b1;
      end
    end
    chk("run_done", done, 1);
    last_nw = nw;
    last_nb = nb;
  endtask

  initial begin
    int nz;
    rst = 1'b1;
    run = 1'b0;
    sel = 2'd0;
    init_req = 1'b0;
    init_w = '0;
    init_g = '0;
    repeat (3) @(negedge clk);
    chk("reset_wdata", wdata_w, '0);
    chk("reset_ctl", {valid, raddr_w, waddr_w, we_w, raddr_b, waddr_b, wdata_b, we_b}, '0);
    rst = 1'b0;

    // Nominal update of layer 1.
    load(24'h000100, 24'h000400);
    do_run(2'd1, -1, 1'b0, 24'h0000F0, 24'h0000F0);
    chk("nom_nw", last_nw, 72);
    chk("nom_nb", last_nb, 24);
    chk("nom_valid_cyc", last_vcyc, 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold", {valid, we_w, we_b}, 3'b100);
    end
    run = 1'b0;
    @(negedge clk);
    chk("valid_drop", valid, 0);
    nz = 0;
    for (int i = 72; i < 144; i++) if (gwmem[i] != '0) nz++;
    for (int i = 24; i < 48; i++) if (gbmem[i] != '0) nz++;
    chk("grad_clear", nz, 0);
    chk("w_mem_in", wmem[100], {DN{24'h0000F0}});
    chk("w_mem_below", wmem[71], {DN{24'h000100}});
    chk("w_mem_above", wmem[144], {DN{24'h000100}});
    chk("b_mem_in", bmem[30], 24'h0000F0);
    chk("b_mem_above", bmem[48], 24'h000100);
    chk("gw_untouched", gwmem[144], {DN{24'h000400}});

    // Negative gradient floors to -1; sel=3 aliases layer 0.
    load(24'h000000, 24'hFFFFC1);
    do_run(2'd3, -1, 1'b0, 24'h000001, 24'h000001);
    chk("neg_nw", last_nw, 72);
    chk("neg_valid_cyc", last_vcyc, 100);
    run = 1'b0;
    @(negedge clk);

    // Overflow: wrap or clamp depending on build.
    load(24'h7FFFF0, 24'hFFF000);
    do_run(2'd2, -1, 1'b0, EXP_OVF, EXP_OVF);
    chk("ovf_nb", last_nb, 24);
    run = 1'b0;
    @(negedge clk);

    // Abort by dropping run in cycle 40.
    load(24'h000100, 24'h000400);
    do_run(2'd1, 40, 1'b0, 24'h0000F0, 24'h0000F0);
    chk("abort_nw", last_nw, 38);
    chk("abort_nb", last_nb, 0);
    chk("abort_row38_kept", wmem[72 + 38], {DN{24'h000100}});

    // Rerun restarts from the region base.
    load(24'h000100, 24'h000400);
    do_run(2'd1, -1, 1'b0, 24'h0000F0, 24'h0000F0);
    chk("rerun_nw", last_nw, 72);
    chk("rerun_valid_cyc", last_vcyc, 100);
    run = 1'b0;
    @(negedge clk);

    // Reset in cycle 50, then restart with run held high.
    load(24'h000100, 24'h000400);
    do_run(2'd0, 50, 1'b1, 24'h0000F0, 24'h0000F0);
    chk("rst_nw", last_nw, 48);
    load(24'h000100, 24'h000400);
    rst = 1'b0;
    do_run(2'd0, -1, 1'b0, 24'h0000F0, 24'h0000F0);
    chk("post_rst_nw", last_nw, 72);
    chk("post_rst_nb", last_nb, 24);
    chk("post_rst_valid_cyc", last_vcyc, 100);
    run = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
